axi4_reg_slave: RTL and testbench
=================================

# axi4_reg_slave

AXI4 slave register bank that terminates the AXI4 master port of the UART-to-AXI bridge. It exposes NUM_REGS 32-bit read/write control registers to the fabric, with a per-register write pulse. It supports FIXED and INCR bursts of up to 256 beats, and independent read and write channels.

## Interface
Parameters:
- NUM_REGS, 16: number of 32-bit registers (1..256).
- BASE_ADDR, 32'h0000_0000: byte address of register 0; must be 4-byte aligned.
- RESET_VALUE, 32'h0000_0000: reset value of every register.

Ports:
- aclk  in  1  single clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- s_axi_awvalid/awready  in/out  1  write address handshake.
- s_axi_awaddr  in  32  burst start byte address.
- s_axi_awlen  in  8  beats minus one.
- s_axi_awburst  in  2  burst type.
- s_axi_wvalid/wready  in/out  1  write data handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables.
- s_axi_wlast  in  1  last write beat.
- s_axi_bvalid/bready  out/in  1  write response handshake.
- s_axi_bresp  out  2  write response.
- s_axi_arvalid/arready  in/out  1  read address handshake.
- s_axi_araddr  in  32  burst start byte address.
- s_axi_arlen  in  8  beats minus one.
- s_axi_arburst  in  2  burst type.
- s_axi_rvalid/rready  out/in  1  read data handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rlast  out  1  last read beat.
- reg_out  out  32*NUM_REGS  register contents; register i occupies bits [32i+31:32i].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse per written register.

The awsize/arsize, lock, cache, prot and qos inputs are not present. Transfers are 32-bit; narrow writes use wstrb.

## Operation
- Index calculation: index = (addr - BASE_ADDR) >> 2, computed modulo 2^30. An index is in range when it is below NUM_REGS. addr[1:0] is ignored.
- INCR bursts: index increments by 1 per beat. FIXED bursts: index is constant. WRAP (2'b10) and reserved (2'b11) bursts are treated as INCR and flagged SLVERR.
- Write FSM, W_IDLE: awready=1. An AW handshake latches index, length and burst type, then moves to W_DATA.
- Write FSM, W_DATA: wready=1. Each W handshake with an in-range index writes each byte lane whose wstrb bit is 1 and pulses reg_wr_pulse[index]. Out-of-range beats are dropped.
- Write burst end: the burst ends on beat awlen+1, regardless of wlast. A wlast value that mismatches the beat position on any beat sets the SLVERR flag. The FSM then moves to W_RESP.
- Write FSM, W_RESP: bvalid=1. On the B handshake, return to W_IDLE and clear the flags.
- bresp priority across the whole burst: DECERR (2'b11) if any beat was out of range, else SLVERR (2'b10), else OKAY.
- Read FSM, R_IDLE: arready=1. An AR handshake latches the burst and loads beat 0 into the output registers, then moves to R_DATA.
- Read FSM, R_DATA: rvalid=1. On each R handshake the next beat is loaded the same edge; after the handshake with rlast=1, return to R_IDLE.
- Read beat content: rdata is the register value, or 0 when the index is out of range. rresp is given per beat: DECERR when out of range, else SLVERR for WRAP/reserved bursts, else OKAY.
- Concurrency: read and write run fully independently.
- Same-edge collision: if a read beat is loaded on the same edge that a write updates the same register, the read returns the pre-write value.

## Timing
- During reset, all of these are 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, rdata and reg_wr_pulse. Every register is set to RESET_VALUE and both FSMs return to IDLE.
- In the first cycle after areset deasserts, awready=1 and arready=1.
- Write path:
  - AW handshake at edge t: wready=1 from cycle t+1.
  - W handshake at edge t: reg_out and reg_wr_pulse update at cycle t+1; the pulse lasts exactly one cycle.
  - Throughput is one beat per cycle.
  - bvalid rises the cycle after the last W handshake.
  - awready=1 again the cycle after the B handshake.
- Read path:
  - AR handshake at edge t: rvalid=1, rdata and rlast valid at cycle t+1.
  - Throughput is one beat per cycle while rready=1.
  - arready=1 again the cycle after the last R handshake.
- Stall: the R outputs and bvalid/bresp are held stable while the corresponding ready is 0.
- Reset mid-burst: the burst is aborted, no response is issued and registers are restored.

## Test plan
- Single write: awaddr=BASE+8, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF, wlast=1 -> reg 2 = 0xDEADBEEF, reg_wr_pulse=16'h0004 for one cycle, bresp=OKAY.
- Strobe write: wdata=0x11223344, wstrb=4'b0101 to reg 2 holding 0xDEADBEEF -> reg 2 = 0xDE22BE44.
- INCR read: araddr=BASE, arlen=3 with rready toggling -> 4 beats of regs 0..3 in order, rlast only on the 4th beat, all rresp OKAY.
- Range overrun: INCR write at BASE+0x3C, awlen=1 -> reg 15 written, 2nd beat dropped, bresp=DECERR. Read of BASE+0x40 -> rdata=0, rresp=DECERR.
- FIXED burst and wlast error: FIXED write to reg 5, awlen=2, data 1/2/3 with wlast on beat 2 -> reg 5 = 3, bresp=SLVERR.
- Concurrency and reset: reg 1 is read on the same edge it is written 0xA5 -> read returns the old value. Assert areset mid read burst -> rvalid=0 next cycle and all regs return to RESET_VALUE.

Source files
------------

// File: rtl/axi4_reg_slave_if.sv
// rtl/axi4_reg_slave_if.sv - AXI4 write/read channel bundle for the register slave
interface axi4_reg_slave_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output awvalid, awaddr, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, arburst, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
               arvalid, araddr, arlen, arburst, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_reg_slave.sv
// rtl/axi4_reg_slave.sv - AXI4 slave register bank with FIXED/INCR bursts and write pulses
module axi4_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                     aclk,
    input  logic                     areset,
    axi4_reg_slave_if.slave          s_axi,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      reg_wr_pulse
);
    localparam int          IW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [29:0] NUM_IDX = 30'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [31:0] regs [NUM_REGS];

    w_state_t    w_state;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic [29:0] w_idx;
    logic [7:0]  w_cnt, w_len;
    logic        w_fixed, w_slverr, w_decerr;

    r_state_t    r_state;
    logic        arready_q, rvalid_q, rlast_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [29:0] r_idx;
    logic [7:0]  r_cnt, r_len;
    logic        r_fixed, r_slverr;

    // Ready flags come up as 1 out of reset but are masked while reset is held,
    // so the slave accepts addresses from the very first cycle after release.
    assign s_axi.awready = awready_q & ~areset;
    assign s_axi.arready = arready_q & ~areset;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    // Register index is word offset from the base, wrapping modulo 2^30.
    logic [29:0] aw_idx, ar_idx;
    assign aw_idx = 30'((s_axi.awaddr - BASE_ADDR) >> 2);
    assign ar_idx = 30'((s_axi.araddr - BASE_ADDR) >> 2);

    logic w_fire, w_in_range, w_last_beat, w_last_err;
    assign w_fire      = s_axi.wvalid && wready_q;
    assign w_in_range  = w_idx < NUM_IDX;
    assign w_last_beat = w_cnt == w_len;
    assign w_last_err  = s_axi.wlast != w_last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_out
            assign reg_out[32*gi +: 32] = regs[gi];
        end
    endgenerate

    // Write channel FSM and register storage; burst ends on the counted beat, not on wlast.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state      <= W_IDLE;
            awready_q    <= 1'b1;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b00;
            w_idx        <= '0;
            w_cnt        <= '0;
            w_len        <= '0;
            w_fixed      <= 1'b0;
            w_slverr     <= 1'b0;
            w_decerr     <= 1'b0;
            reg_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            reg_wr_pulse <= '0;
            case (w_state)
                W_IDLE: begin
                    if (s_axi.awvalid && s_axi.awready) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_idx     <= aw_idx;
                        w_len     <= s_axi.awlen;
                        w_cnt     <= '0;
                        w_fixed   <= s_axi.awburst == 2'b00;
                        w_slverr  <= s_axi.awburst[1];
                        w_decerr  <= 1'b0;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_in_range) begin
                            for (int b = 0; b < 4; b++) begin
                                if (s_axi.wstrb[b]) regs[w_idx[IW-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
                            end
                            reg_wr_pulse[w_idx[IW-1:0]] <= 1'b1;
                        end else begin
                            w_decerr <= 1'b1;
                        end
                        if (w_last_err) w_slverr <= 1'b1;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            if (!w_in_range || w_decerr)     bresp_q <= 2'b11;
                            else if (w_slverr || w_last_err) bresp_q <= 2'b10;
                            else                             bresp_q <= 2'b00;
                            w_state  <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                            if (!w_fixed) w_idx <= w_idx + 30'd1;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= 2'b00;
                        awready_q <= 1'b1;
                        w_slverr  <= 1'b0;
                        w_decerr  <= 1'b0;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Next read beat: taken from the AR channel when idle, else stepped from the current beat.
    logic [29:0] r_next_idx;
    logic        r_next_in, r_next_slv;
    logic [31:0] r_next_data;
    logic [1:0]  r_next_resp;
    always_comb begin
        r_next_idx  = (r_state == R_IDLE) ? ar_idx : (r_fixed ? r_idx : r_idx + 30'd1);
        r_next_slv  = (r_state == R_IDLE) ? s_axi.arburst[1] : r_slverr;
        r_next_in   = r_next_idx < NUM_IDX;
        r_next_data = 32'h0;
        if (r_next_in) r_next_data = regs[r_next_idx[IW-1:0]];
        r_next_resp = !r_next_in ? 2'b11 : (r_next_slv ? 2'b10 : 2'b00);
    end

    // Read channel FSM; beats are registered so a same-edge write is seen only by later beats.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_fixed   <= 1'b0;
            r_slverr  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi.arvalid && s_axi.arready) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_idx     <= r_next_idx;
                        r_len     <= s_axi.arlen;
                        r_cnt     <= '0;
                        r_fixed   <= s_axi.arburst == 2'b00;
                        r_slverr  <= s_axi.arburst[1];
                        rdata_q   <= r_next_data;
                        rresp_q   <= r_next_resp;
                        rlast_q   <= s_axi.arlen == 8'd0;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rdata_q   <= '0;
                            rresp_q   <= 2'b00;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_idx   <= r_next_idx;
                            r_cnt   <= r_cnt + 8'd1;
                            rdata_q <= r_next_data;
                            rresp_q <= r_next_resp;
                            rlast_q <= (r_cnt + 8'd1) == r_len;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_reg_slave.sv
// tb/tb_axi4_reg_slave.sv - directed and randomized bench for axi4_reg_slave
module tb_axi4_reg_slave;
    localparam int          NUM_REGS = 16;
    localparam logic [31:0] BASE     = 32'h4000_1000;
    localparam logic [31:0] RV       = 32'hCAFE_0001;

    logic aclk;
    logic areset;
    logic [32*NUM_REGS-1:0] reg_out;
    logic [NUM_REGS-1:0]    reg_wr_pulse;

    axi4_reg_slave_if bus ();

    axi4_reg_slave #(
        .NUM_REGS    (NUM_REGS),
        .BASE_ADDR   (BASE),
        .RESET_VALUE (RV)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axi        (bus.slave),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model [NUM_REGS];
    logic [31:0] wd [$];
    logic [3:0]  ws [$];
    logic        wl [$];

    function automatic logic [511:0] flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = RV;
    endtask

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return 30'((addr - BASE) >> 2);
    endfunction

    // Caller fills wd/ws/wl with len+1 entries; starts and ends 1 time unit after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        logic [29:0] idx;
        logic [NUM_REGS-1:0] ep;
        logic oor, slv;
        int cyc;
        oor = 1'b0;
        slv = burst[1];
        bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
        cyc = 0;
        while (bus.awready !== 1'b1 && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        chk("aw_ready_wait", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        chk("w_ready_after_aw", bus.wready, 1'b1);
        chk("aw_busy", bus.awready, 1'b0);
        for (int i = 0; i <= int'(len); i++) begin
            idx = (burst == 2'b00) ? word_idx(addr) : word_idx(addr) + 30'(i);
            if (wl[i] != (i == int'(len))) slv = 1'b1;
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = wl[i]; bus.wvalid = 1'b1;
            chk("w_ready_beat", bus.wready, 1'b1);
            @(posedge aclk); #1;
            ep = '0;
            if (idx < 30'(NUM_REGS)) begin
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[idx[3:0]][8*b +: 8] = wd[i][8*b +: 8];
                ep[idx[3:0]] = 1'b1;
            end else begin
                oor = 1'b1;
            end
            chk("wr_pulse", reg_wr_pulse, ep);
            chk("reg_out_w", reg_out, flat());
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("w_ready_done", bus.wready, 1'b0);
        chk("bvalid", bus.bvalid, 1'b1);
        chk("bresp", bus.bresp, oor ? 2'b11 : (slv ? 2'b10 : 2'b00));
        repeat ($urandom_range(0, 2)) begin
            @(posedge aclk); #1;
            chk("bvalid_hold", bus.bvalid, 1'b1);
            chk("bresp_hold", bus.bresp, oor ? 2'b11 : (slv ? 2'b10 : 2'b00));
            chk("pulse_idle", reg_wr_pulse, '0);
        end
        bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.bready = 1'b0;
        chk("bvalid_clear", bus.bvalid, 1'b0);
        chk("aw_ready_again", bus.awready, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input bit toggle);
        logic [29:0] idx;
        int i, cyc;
        bit rr;
        bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
        cyc = 0;
        while (bus.arready !== 1'b1 && cyc < 50) begin @(posedge aclk); #1; cyc++; end
        chk("ar_ready_wait", bus.arready, 1'b1);
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        i = 0; cyc = 0;
        while (i <= int'(len) && cyc < 3000) begin
            idx = (burst == 2'b00) ? word_idx(addr) : word_idx(addr) + 30'(i);
            chk("rvalid", bus.rvalid, 1'b1);
            chk("rdata", bus.rdata, (idx < 30'(NUM_REGS)) ? model[idx[3:0]] : 32'h0);
            chk("rresp", bus.rresp, (idx >= 30'(NUM_REGS)) ? 2'b11 : (burst[1] ? 2'b10 : 2'b00));
            chk("rlast", bus.rlast, i == int'(len));
            rr = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rready = rr;
            @(posedge aclk); #1;
            bus.rready = 1'b0;
            if (rr) i++;
            cyc++;
        end
        chk("r_beats", i, int'(len) + 1);
        chk("rvalid_done", bus.rvalid, 1'b0);
        chk("ar_ready_again", bus.arready, 1'b1);
    endtask

    task automatic fill(input int n, input logic [31:0] d, input logic [3:0] s, input bit rnd);
        wd.delete(); ws.delete(); wl.delete();
        for (int i = 0; i < n; i++) begin
            wd.push_back(rnd ? $urandom : d);
            ws.push_back(rnd ? 4'($urandom_range(0, 15)) : s);
            wl.push_back(i == n - 1);
        end
    endtask

    initial begin
        logic [31:0] addr, old1;
        logic [7:0]  len;
        logic [1:0]  burst;

        bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arburst = 0; bus.rready = 0;
        areset = 1'b1;
        model_reset();
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", bus.awready, 1'b0);
        chk("rst_arready", bus.arready, 1'b0);
        chk("rst_wready", bus.wready, 1'b0);
        chk("rst_bvalid", bus.bvalid, 1'b0);
        chk("rst_rvalid", bus.rvalid, 1'b0);
        chk("rst_rlast", bus.rlast, 1'b0);
        chk("rst_bresp", bus.bresp, 2'b00);
        chk("rst_rresp", bus.rresp, 2'b00);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_pulse", reg_wr_pulse, '0);
        chk("rst_regs", reg_out, flat());
        areset = 1'b0;
        #1;
        chk("post_rst_awready", bus.awready, 1'b1);
        chk("post_rst_arready", bus.arready, 1'b1);
        @(posedge aclk); #1;

        // Single write, then strobe merge into reg 2.
        fill(1, 32'hDEADBEEF, 4'hF, 0);
        do_write(BASE + 32'h8, 8'd0, 2'b01);
        chk("reg2_full", reg_out[95:64], 32'hDEADBEEF);
        fill(1, 32'h11223344, 4'b0101, 0);
        do_write(BASE + 32'h8, 8'd0, 2'b01);
        chk("reg2_strb", reg_out[95:64], 32'hDE22BE44);

        // INCR read of regs 0..3 with rready toggling.
        do_read(BASE, 8'd3, 2'b01, 1);

        // Overrun past the last register, and read just past the end.
        fill(2, 32'h0, 4'hF, 1);
        do_write(BASE + 32'h3C, 8'd1, 2'b01);
        do_read(BASE + 32'h40, 8'd0, 2'b01, 0);

        // FIXED burst with wlast on the second beat.
        wd = '{32'd1, 32'd2, 32'd3}; ws = '{4'hF, 4'hF, 4'hF}; wl = '{1'b0, 1'b1, 1'b0};
        do_write(BASE + 32'h14, 8'd2, 2'b00);
        chk("reg5_fixed", reg_out[191:160], 32'd3);

        // Longest bursts.
        fill(256, 32'h0, 4'h0, 1);
        do_write(BASE + 32'hC, 8'd255, 2'b00);
        do_read(BASE, 8'd255, 2'b01, 0);

        // Randomized traffic including WRAP/reserved bursts and addresses below BASE.
        for (int k = 0; k < 30; k++) begin
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 3));
            addr  = ($urandom_range(0, 7) == 0) ? BASE - 32'h8
                                                : BASE + 32'(4 * $urandom_range(0, 19)) + 32'($urandom_range(0, 3));
            fill(int'(len) + 1, 32'h0, 4'h0, 1);
            if ($urandom_range(0, 3) == 0) begin
                int e;
                e = $urandom_range(0, int'(len));
                wl[e] = ~wl[e];
            end
            do_write(addr, len, burst);
            len   = 8'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 3));
            addr  = BASE + 32'(4 * $urandom_range(0, 19)) + 32'($urandom_range(0, 3));
            do_read(addr, len, burst, 1);
        end

        // Read and write of reg 1 on the same edge: read sees the old value.
        old1 = model[1];
        bus.awaddr = BASE + 32'h4; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awvalid = 1'b1;
        chk("coll_awready", bus.awready, 1'b1);
        @(posedge aclk); #1;
        bus.awvalid = 1'b0;
        bus.wdata = 32'h0000_00A5; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = BASE + 32'h4; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        chk("coll_ready", {bus.wready, bus.arready}, 2'b11);
        @(posedge aclk); #1;
        bus.wvalid = 1'b0; bus.arvalid = 1'b0; bus.wlast = 1'b0;
        model[1] = 32'h0000_00A5;
        chk("coll_rdata", bus.rdata, old1);
        chk("coll_rvalid", bus.rvalid, 1'b1);
        chk("coll_reg", reg_out, flat());
        chk("coll_bvalid", bus.bvalid, 1'b1);
        bus.rready = 1'b1; bus.bready = 1'b1;
        @(posedge aclk); #1;
        bus.rready = 1'b0; bus.bready = 1'b0;
        do_read(BASE + 32'h4, 8'd0, 2'b01, 0);

        // Reset in the middle of a read burst.
        fill(1, 32'h0, 4'hF, 1);
        do_write(BASE, 8'd0, 2'b01);
        bus.araddr = BASE; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arvalid = 1'b1;
        @(posedge aclk); #1;
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("mid_rvalid", bus.rvalid, 1'b1);
        bus.rready = 1'b0;
        areset = 1'b1;
        @(posedge aclk); #1;
        model_reset();
        chk("abort_rvalid", bus.rvalid, 1'b0);
        chk("abort_regs", reg_out, flat());
        chk("abort_bvalid", bus.bvalid, 1'b0);
        areset = 1'b0;
        @(posedge aclk); #1;
        do_read(BASE, 8'd3, 2'b01, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
